// File: rtl/vector_merge_sequencer.sv
// rtl/vector_merge_sequencer.sv - sequences vmerge.v*m beats between the VRF and the merge unit
module vector_merge_sequencer #(
  parameter int VLEN     = 512,
  parameter int BEATS    = VLEN / 64,
  parameter int VL_WIDTH = $clog2(VLEN / 8) + 1,
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [4:0]          issue_vd,
  input  logic [4:0]          issue_vs1,
  input  logic [4:0]          issue_vs2,
  input  logic [1:0]          issue_sew,
  input  logic [VL_WIDTH-1:0] issue_vl,
  output logic                vrf_read_enable,
  output logic [4:0]          vrf_read_address_a,
  output logic [4:0]          vrf_read_address_b,
  output logic [BW-1:0]       vrf_read_beat,
  input  logic [63:0]         vrf_read_data_a,
  input  logic [63:0]         vrf_read_data_b,
  output logic [1:0]          merge_sew,
  output logic [63:0]         merge_vs1,
  output logic [63:0]         merge_vs2,
  output logic [63:0]         merge_v0,
  input  logic [63:0]         merge_vd,
  output logic                vrf_write_enable,
  output logic [4:0]          vrf_write_address,
  output logic [BW-1:0]       vrf_write_beat,
  output logic [63:0]         vrf_write_data,
  output logic [7:0]          vrf_write_byte_enable,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE, S_MASK_READ, S_MASK_CAPTURE, S_BEAT_READ, S_BEAT_WRITE, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic [1:0]          sew_q, sew_d;
  logic [VL_WIDTH-1:0] vl_q, vl_d;
  logic [63:0]         mask_q, mask_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                wr_en_q, wr_en_d;
  logic [4:0]          wr_addr_q, wr_addr_d;
  logic [BW-1:0]       wr_beat_q, wr_beat_d;
  logic [63:0]         wr_data_q, wr_data_d;
  logic [7:0]          wr_be_q, wr_be_d;

  // 8-bit working arithmetic: every count here is at most VLEN/8 = 64
  logic [7:0] vl8, e8, nb8, last_elems8, last_bytes8, shift8, vlmax8, in_vl8;
  logic [7:0] be_last;
  logic       last_beat;

  // Per-instruction geometry derived from the latched sew/vl
  always_comb begin
    vl8         = 8'(vl_q);
    e8          = 8'd8 >> sew_q;
    nb8         = (vl8 + e8 - 8'd1) >> (2'd3 - sew_q);
    last_elems8 = vl8 - (nb8 - 8'd1) * e8;
    last_bytes8 = last_elems8 << sew_q;
    be_last     = 8'hFF >> (8'd8 - last_bytes8);
    shift8      = 8'(beat_q) * e8;
    last_beat   = (8'(beat_q) == (nb8 - 8'd1));
    vlmax8      = 8'(VLEN / 8) >> issue_sew;
    in_vl8      = 8'(issue_vl);
  end

  // Next-state logic and combinational outputs of the sequencing FSM
  always_comb begin
    state_d            = state_q;
    vd_d               = vd_q;
    vs1_d              = vs1_q;
    vs2_d              = vs2_q;
    sew_d              = sew_q;
    vl_d               = vl_q;
    mask_d             = mask_q;
    beat_d             = beat_q;
    wr_en_d            = 1'b0;
    wr_addr_d          = 5'd0;
    wr_beat_d          = '0;
    wr_data_d          = 64'd0;
    wr_be_d            = 8'd0;
    issue_ready        = 1'b0;
    vrf_read_enable    = 1'b0;
    vrf_read_address_a = 5'd0;
    vrf_read_address_b = 5'd0;
    vrf_read_beat      = '0;
    merge_sew          = 2'd0;
    merge_vs1          = 64'd0;
    merge_vs2          = 64'd0;
    merge_v0           = 64'd0;
    busy               = (state_q != S_IDLE);
    done               = 1'b0;
    case (state_q)
      S_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) begin
          vd_d    = issue_vd;
          vs1_d   = issue_vs1;
          vs2_d   = issue_vs2;
          sew_d   = issue_sew;
          vl_d    = VL_WIDTH'((in_vl8 > vlmax8) ? vlmax8 : in_vl8);
          state_d = S_MASK_READ;
        end
      end
      S_MASK_READ: begin
        // An empty instruction retires without touching the VRF
        if (vl_q == '0) begin
          state_d = S_DONE;
        end else begin
          vrf_read_enable = 1'b1;
          state_d         = S_MASK_CAPTURE;
        end
      end
      S_MASK_CAPTURE: begin
        mask_d  = vrf_read_data_a;
        beat_d  = '0;
        state_d = S_BEAT_READ;
      end
      S_BEAT_READ: begin
        vrf_read_enable    = 1'b1;
        vrf_read_address_a = vs1_q;
        vrf_read_address_b = vs2_q;
        vrf_read_beat      = beat_q;
        state_d            = S_BEAT_WRITE;
      end
      S_BEAT_WRITE: begin
        merge_sew = sew_q;
        merge_vs1 = vrf_read_data_a;
        merge_vs2 = vrf_read_data_b;
        merge_v0  = mask_q >> shift8;
        wr_en_d   = 1'b1;
        wr_addr_d = vd_q;
        wr_beat_d = beat_q;
        wr_data_d = merge_vd;
        wr_be_d   = last_beat ? be_last : 8'hFF;
        beat_d    = beat_q + BW'(1);
        state_d   = last_beat ? S_DONE : S_BEAT_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched instruction fields and the registered write port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      vd_q      <= 5'd0;
      vs1_q     <= 5'd0;
      vs2_q     <= 5'd0;
      sew_q     <= 2'd0;
      vl_q      <= '0;
      mask_q    <= 64'd0;
      beat_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_beat_q <= '0;
      wr_data_q <= 64'd0;
      wr_be_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      vd_q      <= vd_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      sew_q     <= sew_d;
      vl_q      <= vl_d;
      mask_q    <= mask_d;
      beat_q    <= beat_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_beat_q <= wr_beat_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
    end
  end

  assign vrf_write_enable      = wr_en_q;
  assign vrf_write_address     = wr_addr_q;
  assign vrf_write_beat        = wr_beat_q;
  assign vrf_write_data        = wr_data_q;
  assign vrf_write_byte_enable = wr_be_q;

endmodule

// File: tb/tb_vector_merge_sequencer.sv
// tb/tb_vector_merge_sequencer.sv - scoreboard bench for vector_merge_sequencer
module tb_vector_merge_sequencer;
  localparam int VLEN  = 512;
  localparam int BEATS = VLEN / 64;
  localparam int VLW   = $clog2(VLEN / 8) + 1;
  localparam int BW    = $clog2(BEATS);

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           issue_valid = 1'b0;
  logic           issue_ready;
  logic [4:0]     issue_vd = 5'd0, issue_vs1 = 5'd0, issue_vs2 = 5'd0;
  logic [1:0]     issue_sew = 2'd0;
  logic [VLW-1:0] issue_vl = '0;
  logic           vrf_read_enable;
  logic [4:0]     vrf_read_address_a, vrf_read_address_b;
  logic [BW-1:0]  vrf_read_beat;
  logic [63:0]    vrf_read_data_a = 64'd0, vrf_read_data_b = 64'd0;
  logic [1:0]     merge_sew;
  logic [63:0]    merge_vs1, merge_vs2, merge_v0, merge_vd;
  logic           vrf_write_enable;
  logic [4:0]     vrf_write_address;
  logic [BW-1:0]  vrf_write_beat;
  logic [63:0]    vrf_write_data;
  logic [7:0]     vrf_write_byte_enable;
  logic           busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          beat;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;
  wr_t sb[$];

  logic [63:0] vrf [32][BEATS];
  logic        fill = 1'b0;
  logic        load_en = 1'b0;
  logic [63:0] load_data = 64'd0;

  vector_merge_sequencer #(.VLEN(VLEN)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_vd(issue_vd), .issue_vs1(issue_vs1), .issue_vs2(issue_vs2),
    .issue_sew(issue_sew), .issue_vl(issue_vl),
    .vrf_read_enable(vrf_read_enable),
    .vrf_read_address_a(vrf_read_address_a), .vrf_read_address_b(vrf_read_address_b),
    .vrf_read_beat(vrf_read_beat),
    .vrf_read_data_a(vrf_read_data_a), .vrf_read_data_b(vrf_read_data_b),
    .merge_sew(merge_sew), .merge_vs1(merge_vs1), .merge_vs2(merge_vs2),
    .merge_v0(merge_v0), .merge_vd(merge_vd),
    .vrf_write_enable(vrf_write_enable), .vrf_write_address(vrf_write_address),
    .vrf_write_beat(vrf_write_beat), .vrf_write_data(vrf_write_data),
    .vrf_write_byte_enable(vrf_write_byte_enable),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Element-wise vmerge: mask bit i selects element i of a, else of b
  function automatic logic [63:0] merge64(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] m, input logic [1:0] sew);
    int esz = 8 << sew;
    logic [63:0] r = 64'd0;
    for (int i = 0; i < 64 / esz; i++)
      for (int j = 0; j < esz; j++)
        r[i*esz+j] = m[i] ? a[i*esz+j] : b[i*esz+j];
    return r;
  endfunction

  assign merge_vd = merge64(merge_vs1, merge_vs2, merge_v0, merge_sew);

  // VRF model: random fill, v0 preload, 1-cycle reads, byte-enabled writes
  always @(posedge clock) begin
    if (fill) begin
      for (int r = 0; r < 32; r++)
        for (int b = 0; b < BEATS; b++)
          vrf[r][b] <= {$urandom, $urandom};
    end else if (load_en) begin
      vrf[0][0] <= load_data;
    end else if (vrf_write_enable) begin
      for (int i = 0; i < 8; i++)
        if (vrf_write_byte_enable[i])
          vrf[vrf_write_address][vrf_write_beat][i*8+:8] <= vrf_write_data[i*8+:8];
    end
    if (vrf_read_enable) begin
      vrf_read_data_a <= vrf[vrf_read_address_a][vrf_read_beat];
      vrf_read_data_b <= vrf[vrf_read_address_b][vrf_read_beat];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_v0(input logic [63:0] d);
    @(negedge clock);
    load_data = d;
    load_en   = 1'b1;
    @(negedge clock);
    load_en   = 1'b0;
  endtask

  // Issue one instruction, score its writes and completion; abort_at>0 pulls reset at that cycle
  task automatic run(input string name, input logic [4:0] vd, input logic [4:0] vs1,
                     input logic [4:0] vs2, input logic [1:0] sew, input int vl,
                     input int abort_at);
    int vlmax = 64 >> sew;
    int e     = 8 >> sew;
    int vle   = (vl > vlmax) ? vlmax : vl;
    int nb    = (vle + e - 1) / e;
    int exp_done = (vle == 0) ? 2 : 3 + 2 * nb;
    logic [63:0] mask = vrf[0][0];
    bit seen = 0;
    bit aborted = 0;
    sb.delete();
    for (int b = 0; b < nb; b++) begin
      wr_t w;
      int elems = vle - b * e;
      int bytes;
      if (elems > e) elems = e;
      bytes  = elems * (1 << sew);
      w.beat = b;
      w.be   = (bytes == 8) ? 8'hFF : 8'((1 << bytes) - 1);
      w.data = merge64(vrf[vs1][b], vrf[vs2][b], mask >> (b * e), sew);
      sb.push_back(w);
    end
    @(negedge clock);
    issue_vd = vd; issue_vs1 = vs1; issue_vs2 = vs2; issue_sew = sew;
    issue_vl = VLW'(vl);
    issue_valid = 1'b1;
    #1 check({name, "_issue_ready"}, 64'(issue_ready), 64'd1);
    @(posedge clock);
    #1 issue_valid = 1'b0;
    for (int k = 1; k <= exp_done + 6 && !seen && !aborted; k++) begin
      @(negedge clock);
      if (vrf_write_enable) begin
        if (sb.size() == 0) begin
          check({name, "_unexpected_write"}, 64'(vrf_write_beat), 64'hDEAD);
        end else begin
          wr_t w = sb.pop_front();
          check({name, "_wr_addr"}, 64'(vrf_write_address), 64'(vd));
          check({name, "_wr_beat"}, 64'(vrf_write_beat), 64'(w.beat));
          check({name, "_wr_data"}, vrf_write_data, w.data);
          check({name, "_wr_be"}, 64'(vrf_write_byte_enable), 64'(w.be));
        end
      end
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check({name, "_rst_busy"}, 64'(busy), 64'd0);
        check({name, "_rst_wen"}, 64'(vrf_write_enable), 64'd0);
        check({name, "_rst_ren"}, 64'(vrf_read_enable), 64'd0);
        check({name, "_rst_v0"}, merge_v0, 64'd0);
        repeat (3) begin
          @(negedge clock);
          check({name, "_rst_no_write"}, 64'(vrf_write_enable), 64'd0);
          check({name, "_rst_no_done"}, 64'(done), 64'd0);
        end
        reset_n = 1'b1;
        sb.delete();
        aborted = 1;
      end else begin
        if (vle == 0) check({name, "_no_read"}, 64'(vrf_read_enable), 64'd0);
        if (done) begin
          check({name, "_done_cycle"}, 64'(k), 64'(exp_done));
          seen = 1;
        end
      end
    end
    if (!aborted) begin
      check({name, "_done_seen"}, 64'(seen), 64'd1);
      check({name, "_writes_left"}, 64'(sb.size()), 64'd0);
      @(negedge clock);
      check({name, "_ready_after"}, 64'(issue_ready), 64'd1);
      check({name, "_done_one_cycle"}, 64'(done), 64'd0);
      check({name, "_merge_idle"}, merge_vs1, 64'd0);
    end else begin
      @(negedge clock);
      check({name, "_ready_after_rst"}, 64'(issue_ready), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] old_tail, exp_lo;
    fill = 1'b1;
    @(negedge clock);
    fill = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_wen", 64'(vrf_write_enable), 64'd0);
    check("reset_ren", 64'(vrf_read_enable), 64'd0);
    check("reset_v0", merge_v0, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_ready", 64'(issue_ready), 64'd1);

    load_v0(64'h5);
    run("t1_sew64", 5'd3, 5'd1, 5'd2, 2'd3, 8, 0);

    load_v0(64'h1FFF);
    run("t2_sew8", 5'd4, 5'd5, 5'd6, 2'd0, 13, 0);

    load_v0(64'h0);
    old_tail = vrf[7][1];
    exp_lo   = vrf[2][1];
    run("t3_sew16", 5'd7, 5'd1, 5'd2, 2'd1, 5, 0);
    check("t3_tail_undisturbed", vrf[7][1],
          (old_tail & ~64'hFFFF) | (exp_lo & 64'hFFFF));

    run("t4_vl0", 5'd8, 5'd1, 5'd2, 2'd2, 0, 0);

    load_v0({$urandom, $urandom});
    run("t5_clamp", 5'd9, 5'd5, 5'd6, 2'd2, 40, 0);

    load_v0(64'h5);
    run("t6_abort", 5'd3, 5'd1, 5'd2, 2'd3, 8, 9);
    load_v0(64'h1FFF);
    run("t6_resume", 5'd4, 5'd5, 5'd6, 2'd0, 13, 0);

    load_v0({$urandom, $urandom});
    run("t7_alias", 5'd10, 5'd10, 5'd11, 2'd1, 27, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
